irq_pending_latch: RTL and testbench
====================================

// Module: irq_pending_latch
// PURPOSE
//   Upstream stage of the 4-to-2 priority encoder. Synchronises N raw request lines and
//   turns each rising edge into a sticky pending bit. Presents the masked pending vector
//   as the encoder's D input and raises irq while any unmasked bit is pending.
//   The consumer clears a serviced bit by acknowledging its index, normally the encoder's Y.
// PARAMETERS
//   N            4   number of request lines; must equal the encoder input width
//   SYNC_STAGES  2   flip-flop synchroniser depth per line, >=2
//   IW           2   ack index width, $clog2(N); localparam, not overridable
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   req_in     in   N    raw async request levels; a 0->1 transition is one event
//   mask       in   N    1 = line masked: pending still latches, but is hidden from pend_out/irq
//   ack_valid  in   1    single-cycle strobe: clear pending[ack_idx]
//   ack_idx    in   IW   index being acknowledged
//   pend_out   out  N    pending & ~mask, registered; drives encoder D
//   irq        out  1    |pend_out, registered
//   ack_err    out  1    1-cycle pulse: ack for a bit not set in pend_out
//   ovf        out  N    sticky: a new edge arrived while that bit was already pending
//   ovf_clr    in   1    clears all ovf bits; set has priority in the same cycle
// BEHAVIOUR
//   - Reset, async assert and sync release: sync chains, edge-prev regs, pending,
//     pend_out, irq, ack_err and ovf all go to 0.
//   - A line held high across reset release counts as one edge.
//   - Edge detect: edge[i] = sync[i] & ~prev[i], evaluated on the last synchroniser stage.
//   - Latency: req_in 0->1 stable before edge k -> pending[i]=1 after edge k+SYNC_STAGES.
//     pend_out and irq follow one cycle later, so SYNC_STAGES+1 cycles in total.
//   - Next-state per bit:
//       pending_n = edge | (pending & ~(ack_valid & ack_idx==i & pend_out[i]))
//     - Edge and ack on the same bit in the same cycle: pending stays 1 and ovf is not set.
//       The new event survives.
//     - Edge while pending=1 and no ack for that bit: pending stays 1 and ovf[i] <= 1.
//       Events coalesce and are never counted.
//   - Ack rules:
//     - Accepted only when pend_out[ack_idx]=1 (registered value).
//     - Otherwise no state change and ack_err pulses the next cycle. This covers an ack to a
//       masked bit, a non-pending bit, or any ack while irq=0.
//   - Mask is combinational into the pend_out register; it has no effect on pending or ovf.
//     - Unmasking a latched bit makes it visible on pend_out one cycle later.
//   - No ready/back-pressure: events are never lost except by coalescing, which ovf flags.
//   - Reset mid-operation: all pending and ovf state is discarded, with no partial clears.
// STRUCTURE
//   - Shared package/header: N_IRQ=4, IRQ_IW=2, and the reset-value constant for the
//     N-bit vectors. The encoder consumes the same constants.
//   - One sub-module, sync_edge_det: a SYNC_STAGES synchroniser plus rising-edge detect
//     for 1 bit, instantiated N times with a generate loop.
//   - Top level holds the pending/ovf regs, ack decode, mask and output regs.
// TESTING (bench instantiates irq_pending_latch -> priority_encoder4to2, SYNC_STAGES=2)
//   1 Reset: rst_n=0 with req_in=4'b0000 -> pend_out=0, irq=0, ovf=0, ack_err=0.
//     Assert rst_n=0 mid-run with pending=4'b1010 -> all 0 immediately, without a clock.
//   2 Latency: pulse req_in[2] high for 1 cycle -> pend_out=4'b0100 and irq=1 exactly
//     3 clocks later, encoder Y=2'b10. Ack idx 2 -> pend_out=0, irq=0 the next cycle.
//   3 Priority chain: edges on bits 1 and 3 together -> pend_out=4'b1010, Y=2'b11.
//     Ack Y -> pend_out=4'b0010, Y=2'b01. Ack Y -> pend_out=0, irq=0.
//   4 Mask: mask=4'b1000, edge on bit 3 -> pend_out=0, irq=0, internal pending[3]=1.
//     Ack idx 3 -> ack_err pulse, no clear. mask=0 -> pend_out=4'b1000 the next cycle.
//   5 Coalesce/ovf: two edges on bit 0 with no ack -> pend_out=4'b0001, ovf=4'b0001.
//     ovf_clr -> ovf=0, pend_out unchanged.
//   6 Same-cycle race: an edge on bit 1 reaches the detector in the same cycle as
//     ack idx 1 -> pend_out[1] stays 1 and ovf[1]=0. A spurious ack idx 0 with
//     pend_out=4'b0010 -> ack_err=1 for 1 cycle.

Source files
------------

// File: rtl/irq_pending_latch_pkg.sv
// rtl/irq_pending_latch_pkg.sv - shared constants for the interrupt pending latch and its encoder
package irq_pending_latch_pkg;

  localparam int N_IRQ  = 4;
  localparam int IRQ_IW = 2;

  localparam logic [N_IRQ-1:0] IRQ_VEC_RST = '0;

endpackage

// File: rtl/irq_pending_latch_sync_edge_det.sv
// rtl/irq_pending_latch_sync_edge_det.sv - per-line synchroniser and rising-edge detector
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the raw level through the synchroniser and remember the last stage's previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // prev resets to 0, so a line already high at reset release yields exactly one rise
  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - sticky pending bits with mask, ack and overflow for the priority encoder
module irq_pending_latch
  import irq_pending_latch_pkg::*;
#(
  parameter  int N           = N_IRQ,
  parameter  int SYNC_STAGES = 2,
  localparam int IW          = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic [N-1:0]  mask,
  input  logic          ack_valid,
  input  logic [IW-1:0] ack_idx,
  output logic [N-1:0]  pend_out,
  output logic          irq,
  output logic          ack_err,
  output logic [N-1:0]  ovf,
  input  logic          ovf_clr
);

  logic [N-1:0] rise;
  logic [N-1:0] pending;
  logic [N-1:0] clr;
  logic [N-1:0] pending_n;
  logic [N-1:0] ovf_set;
  logic [N-1:0] visible_n;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (req_in[i]),
      .rise (rise[i])
    );
  end

  // Decode an accepted ack into a one-hot clear; only bits visible on pend_out may be cleared
  always_comb begin
    clr = IRQ_VEC_RST;
    if (ack_valid && pend_out[ack_idx]) begin
      clr[ack_idx] = 1'b1;
    end
  end

  // A fresh edge always wins over a clear on the same bit; overflow only when nothing consumed the old event
  always_comb begin
    pending_n = rise | (pending & ~clr);
    ovf_set   = rise & pending & ~clr;
    // The ack takes effect on pend_out immediately, unless a new event on that bit keeps it alive
    visible_n = pending & ~(clr & ~rise) & ~mask;
  end

  // Pending, overflow and the registered encoder-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= IRQ_VEC_RST;
      ovf      <= IRQ_VEC_RST;
      pend_out <= IRQ_VEC_RST;
      irq      <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      pending  <= pending_n;
      ovf      <= (ovf & ~{N{ovf_clr}}) | ovf_set;
      pend_out <= visible_n;
      irq      <= |visible_n;
      ack_err  <= ack_valid & ~pend_out[ack_idx];
    end
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed scoreboard bench for irq_pending_latch
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       ack_valid;
  logic [1:0] ack_idx;
  logic [3:0] pend_out;
  logic       irq;
  logic       ack_err;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] pend;
    logic       irq;
    logic       err;
    logic [3:0] ovf;
  } exp_t;

  exp_t exp_q[$];

  irq_pending_latch #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .ack_valid(ack_valid),
    .ack_idx  (ack_idx),
    .pend_out (pend_out),
    .irq      (irq),
    .ack_err  (ack_err),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference 4-to-2 priority encoder: highest set bit wins
  function automatic logic [1:0] enc(input logic [3:0] d);
    if (d[3]) return 2'd3;
    if (d[2]) return 2'd2;
    if (d[1]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] p, input logic i,
                      input logic e, input logic [3:0] o);
    exp_t x;
    x.tag = tag; x.pend = p; x.irq = i; x.err = e; x.ovf = o;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk({x.tag, "_pend"}, pend_out, x.pend);
      chk({x.tag, "_irq"}, {3'b0, irq}, {3'b0, x.irq});
      chk({x.tag, "_err"}, {3'b0, ack_err}, {3'b0, x.err});
      chk({x.tag, "_ovf"}, ovf, x.ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_in = 4'b0; mask = 4'b0;
    ack_valid = 1'b0; ack_idx = 2'd0; ovf_clr = 1'b0;

    // 1 reset state
    push("rst", 4'h0, 0, 0, 4'h0); tick();
    rst_n = 1'b1;
    push("idle", 4'h0, 0, 0, 4'h0); tick();

    // 2 latency: one-cycle pulse on bit 2
    req_in = 4'b0100;
    push("lat1", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("lat2", 4'h0, 0, 0, 4'h0); tick();
    push("lat3", 4'h0, 0, 0, 4'h0); tick();
    push("lat4", 4'b0100, 1, 0, 4'h0); tick();
    chk("lat_y", {2'b0, enc(pend_out)}, 4'd2);
    ack_valid = 1'b1; ack_idx = 2'd2;
    push("lat_ack", 4'h0, 0, 0, 4'h0); tick();
    ack_valid = 1'b0;
    push("lat_idle", 4'h0, 0, 0, 4'h0); tick();

    // 3 priority chain on bits 3 and 1
    req_in = 4'b1010;
    push("pri1", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("pri2", 4'h0, 0, 0, 4'h0); tick();
    push("pri3", 4'h0, 0, 0, 4'h0); tick();
    push("pri4", 4'b1010, 1, 0, 4'h0); tick();
    chk("pri_y3", {2'b0, enc(pend_out)}, 4'd3);
    ack_valid = 1'b1; ack_idx = enc(pend_out);
    push("pri_ack3", 4'b0010, 1, 0, 4'h0); tick();
    chk("pri_y1", {2'b0, enc(pend_out)}, 4'd1);
    ack_idx = enc(pend_out);
    push("pri_ack1", 4'h0, 0, 0, 4'h0); tick();
    ack_valid = 1'b0;

    // 4 masked bit 3 latches but stays hidden
    mask = 4'b1000; req_in = 4'b1000;
    push("msk1", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("msk2", 4'h0, 0, 0, 4'h0); tick();
    push("msk3", 4'h0, 0, 0, 4'h0); tick();
    push("msk4", 4'h0, 0, 0, 4'h0); tick();
    chk("msk_pending3", {3'b0, dut.pending[3]}, 4'd1);
    ack_valid = 1'b1; ack_idx = 2'd3;
    push("msk_ack", 4'h0, 0, 1, 4'h0); tick();
    ack_valid = 1'b0;
    push("msk_errdrop", 4'h0, 0, 0, 4'h0); tick();
    mask = 4'b0000;
    push("msk_unmask", 4'b1000, 1, 0, 4'h0); tick();
    ack_valid = 1'b1; ack_idx = 2'd3;
    push("msk_clr", 4'h0, 0, 0, 4'h0); tick();
    ack_valid = 1'b0;

    // 5 two edges on bit 0 coalesce and flag overflow
    req_in = 4'b0001;
    push("ovf1", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("ovf2", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0001;
    push("ovf3", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("ovf4", 4'b0001, 1, 0, 4'h0); tick();
    push("ovf5", 4'b0001, 1, 0, 4'b0001); tick();
    ovf_clr = 1'b1;
    push("ovf_clr", 4'b0001, 1, 0, 4'h0); tick();
    ovf_clr = 1'b0;
    ack_valid = 1'b1; ack_idx = 2'd0;
    push("ovf_ack", 4'h0, 0, 0, 4'h0); tick();
    ack_valid = 1'b0;

    // 6 same-cycle edge and ack on bit 1
    req_in = 4'b0010;
    push("race1", 4'h0, 0, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("race2", 4'h0, 0, 0, 4'h0); tick();
    push("race3", 4'h0, 0, 0, 4'h0); tick();
    push("race4", 4'b0010, 1, 0, 4'h0); tick();
    req_in = 4'b0010;
    push("race5", 4'b0010, 1, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("race6", 4'b0010, 1, 0, 4'h0); tick();
    ack_valid = 1'b1; ack_idx = 2'd1;
    push("race_ack", 4'b0010, 1, 0, 4'h0); tick();
    ack_valid = 1'b0;
    push("race_hold", 4'b0010, 1, 0, 4'h0); tick();
    ack_valid = 1'b1; ack_idx = 2'd0;
    push("spur_ack", 4'b0010, 1, 1, 4'h0); tick();
    ack_valid = 1'b0;
    push("spur_drop", 4'b0010, 1, 0, 4'h0); tick();

    // 1b async reset mid-run with pending=1010
    req_in = 4'b1000;
    push("mid1", 4'b0010, 1, 0, 4'h0); tick();
    req_in = 4'b0000;
    push("mid2", 4'b0010, 1, 0, 4'h0); tick();
    push("mid3", 4'b0010, 1, 0, 4'h0); tick();
    push("mid4", 4'b1010, 1, 0, 4'h0); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pend", pend_out, 4'h0);
    chk("arst_irq", {3'b0, irq}, 4'h0);
    chk("arst_ovf", ovf, 4'h0);
    chk("arst_pending", dut.pending, 4'h0);
    #2 rst_n = 1'b1;
    push("post_rst", 4'h0, 0, 0, 4'h0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
